// File: rtl/led_seq_ctrl.sv
// LED index sequencer: debounces three board switches into press events and runs an
// idle/run/pause state machine that steps a 3-bit decoder select at a prescaled rate.
module led_seq_ctrl #(
  parameter int unsigned DEB_CYCLES  = 1_000_000,
  parameter int unsigned TICK_CYCLES = 12_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_n,
  output logic [2:0] sel,
  output logic       running,
  output logic       dir,
  output logic [1:0] speed,
  output logic       step_pulse
);

  localparam int unsigned DebW  = $clog2(DEB_CYCLES);
  localparam int unsigned TickW = $clog2(TICK_CYCLES);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause
  } state_e;

  // Input path: synchronizer, per-key debounce counter, press-edge detect
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      deb_q, deb_d;
  logic [2:0]      deb_prev_q;
  logic [2:0]      press_q;
  logic [DebW-1:0] deb_cnt_q [3];
  logic [DebW-1:0] deb_cnt_d [3];

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int k = 0; k < 3; k++) begin
      if (sync2_q[k] == deb_q[k]) begin
        deb_cnt_d[k] = '0;
      end else if (deb_cnt_q[k] == DebLast) begin
        deb_d[k]     = sync2_q[k];
        deb_cnt_d[k] = '0;
      end else begin
        deb_cnt_d[k] = deb_cnt_q[k] + DebW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      deb_prev_q <= '1;
      press_q    <= '0;
      deb_cnt_q  <= '{default: '0};
    end else begin
      sync1_q    <= key_n;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      // Only debounced 1->0 transitions (presses) produce an event
      press_q    <= deb_prev_q & ~deb_q;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  // Sequencer state
  state_e           state_q;
  logic [2:0]       sel_q;
  logic             running_q;
  logic             dir_q;
  logic [1:0]       speed_q;
  logic             step_q;
  logic [TickW-1:0] presc_q;

  logic [TickW-1:0] period_m1;
  logic             tick;
  logic             dir_eff;
  logic [2:0]       sel_step;

  assign period_m1 = TickW'((TICK_CYCLES >> speed_q) - 32'd1);
  assign tick      = (state_q == StRun) && (presc_q == period_m1);
  // A direction toggle in the same cycle already governs this cycle's step
  assign dir_eff   = dir_q ^ press_q[1];
  assign sel_step  = dir_eff ? (sel_q - 3'd1) : (sel_q + 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      running_q <= 1'b0;
      dir_q     <= 1'b0;
      speed_q   <= '0;
      step_q    <= 1'b0;
      presc_q   <= '0;
    end else begin
      step_q <= 1'b0;
      if (press_q[1]) begin
        dir_q <= ~dir_q;
      end
      if (press_q[0]) begin
        // Run/pause wins: a concurrent speed/step press and any tick are dropped
        case (state_q)
          StRun: begin
            state_q   <= StPause;
            running_q <= 1'b0;
          end
          default: begin
            state_q   <= StRun;
            running_q <= 1'b1;
            presc_q   <= '0;
          end
        endcase
      end else if (press_q[2] && (state_q == StPause)) begin
        sel_q  <= sel_step;
        step_q <= 1'b1;
      end else begin
        if (press_q[2]) begin
          speed_q <= speed_q + 2'd1;
        end
        if (tick) begin
          sel_q  <= sel_step;
          step_q <= 1'b1;
        end
        if (press_q[2] || tick) begin
          presc_q <= '0;
        end else if (state_q == StRun) begin
          presc_q <= presc_q + TickW'(1);
        end
      end
    end
  end

  assign sel        = sel_q;
  assign running    = running_q;
  assign dir        = dir_q;
  assign speed      = speed_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboarded bench for led_seq_ctrl with short debounce and prescaler periods.
module tb_led_seq_ctrl;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Tick = 32;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [2:0] key_n = 3'b111;
  logic [2:0] sel;
  logic       running;
  logic       dir;
  logic [1:0] speed;
  logic       step_pulse;

  int chk_cnt   = 0;
  int pass_cnt  = 0;
  int pulse_cnt = 0;
  int cyc       = 0;

  logic [2:0] exp_q[$];
  logic [2:0] exp_sel = 3'd0;
  logic [2:0] exp_v;

  led_seq_ctrl #(
    .DEB_CYCLES (Deb),
    .TICK_CYCLES(Tick)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .sel       (sel),
    .running   (running),
    .dir       (dir),
    .speed     (speed),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every step pulse must match the next expected select value
  always @(negedge clk) begin
    if (rst === 1'b0 && step_pulse === 1'b1) begin
      pulse_cnt++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: step_pulse with sel=%0d, no step expected", sel);
      end else begin
        exp_v = exp_q.pop_front();
        if (sel !== exp_v) $display("FAIL sb_sel: sel=%0d expected %0d", sel, exp_v);
        else pass_cnt++;
      end
    end
  end

  task automatic push_steps(input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      exp_sel = d ? (exp_sel - 3'd1) : (exp_sel + 3'd1);
      exp_q.push_back(exp_sel);
    end
  endtask

  task automatic press(input logic [2:0] keys);
    key_n = ~keys;
    repeat (10) @(negedge clk);
    key_n = 3'b111;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_pulse(output int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (step_pulse !== 1'b1 && n < 200);
    c = cyc;
  endtask

  task automatic test_reset();
    int n;
    int base;
    int bad = 0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({sel, running, dir, speed, step_pulse} !== 8'h00)
      $display("FAIL reset_por: outputs=%b expected 00000000", {sel, running, dir, speed, step_pulse});
    else pass_cnt++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    press(3'b010);
    press(3'b100);
    press(3'b100);
    chk_cnt++;
    if (dir !== 1'b1) $display("FAIL idle_dir: dir=%0d expected 1", dir);
    else pass_cnt++;
    chk_cnt++;
    if (speed !== 2'd2) $display("FAIL idle_speed: speed=%0d expected 2", speed);
    else pass_cnt++;
    chk_cnt++;
    if (running !== 1'b0) $display("FAIL idle_running: running=%0d expected 0", running);
    else pass_cnt++;
    push_steps(3, 1'b1);
    press(3'b001);
    n = 0;
    while (!(step_pulse === 1'b1 && sel === 3'd5) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (n >= 200) $display("FAIL reset_reach_sel5: waited %0d cycles, limit 200", n);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({sel, running, dir, speed, step_pulse} !== 8'h00)
      $display("FAIL reset_midrun: outputs=%b expected 00000000", {sel, running, dir, speed, step_pulse});
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL reset_sb_left: %0d steps pending, expected 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
    exp_sel = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    #1 base = pulse_cnt;
    repeat (100) begin
      @(negedge clk);
      if (step_pulse !== 1'b0 || sel !== 3'd0 || running !== 1'b0) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL idle_quiet: %0d bad cycles, expected 0", bad);
    else pass_cnt++;
    #1;
    chk_cnt++;
    if (pulse_cnt != base) $display("FAIL idle_pulses: %0d pulses, expected 0", pulse_cnt - base);
    else pass_cnt++;
  endtask

  task automatic test_run_cadence();
    int rise;
    int p;
    int prev;
    push_steps(8, 1'b0);
    key_n[0] = 1'b0;
    rise = cyc;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 7) begin
        chk_cnt++;
        if (running !== 1'b0) $display("FAIL run_latency_early: running=%0d at 6 cycles, expected 0", running);
        else pass_cnt++;
      end
      if (j == 8) begin
        chk_cnt++;
        if (running !== 1'b1) $display("FAIL run_latency: running=%0d at 7 cycles, expected 1", running);
        else pass_cnt++;
        rise = cyc;
      end
    end
    key_n[0] = 1'b1;
    prev = rise;
    for (int i = 0; i < 8; i++) begin
      wait_pulse(p);
      chk_cnt++;
      if (p - prev != 32) $display("FAIL run_period[%0d]: interval=%0d expected 32", i, p - prev);
      else pass_cnt++;
      prev = p;
    end
  endtask

  task automatic test_speed_dir();
    int c;
    int a;
    int b;
    push_steps(12, 1'b0);
    push_steps(7, 1'b1);
    c = cyc;
    press(3'b100);
    chk_cnt++;
    if (speed !== 2'd1) $display("FAIL speed1: speed=%0d expected 1", speed);
    else pass_cnt++;
    wait_pulse(a);
    chk_cnt++;
    if (a - c != 24) $display("FAIL speed1_first: delay=%0d expected 24", a - c);
    else pass_cnt++;
    wait_pulse(b);
    chk_cnt++;
    if (b - a != 16) $display("FAIL speed1_period: interval=%0d expected 16", b - a);
    else pass_cnt++;
    press(3'b100);
    chk_cnt++;
    if (speed !== 2'd2) $display("FAIL speed2: speed=%0d expected 2", speed);
    else pass_cnt++;
    wait_pulse(a);
    wait_pulse(b);
    chk_cnt++;
    if (b - a != 8) $display("FAIL speed2_period: interval=%0d expected 8", b - a);
    else pass_cnt++;
    press(3'b100);
    chk_cnt++;
    if (speed !== 2'd3) $display("FAIL speed3: speed=%0d expected 3", speed);
    else pass_cnt++;
    wait_pulse(a);
    wait_pulse(b);
    chk_cnt++;
    if (b - a != 4) $display("FAIL speed3_period: interval=%0d expected 4", b - a);
    else pass_cnt++;
    press(3'b010);
    chk_cnt++;
    if (dir !== 1'b1) $display("FAIL dir_down: dir=%0d expected 1", dir);
    else pass_cnt++;
    wait_pulse(a);
    wait_pulse(b);
    chk_cnt++;
    if (b - a != 4) $display("FAIL down_period: interval=%0d expected 4", b - a);
    else pass_cnt++;
  endtask

  task automatic test_pause_step();
    int base;
    int bad = 0;
    logic [2:0] want;
    #1 base = pulse_cnt;
    press(3'b001);
    #1;
    chk_cnt++;
    if (running !== 1'b0) $display("FAIL pause_enter: running=%0d expected 0", running);
    else pass_cnt++;
    chk_cnt++;
    if (sel !== 3'd5) $display("FAIL pause_tick_sel: sel=%0d expected 5", sel);
    else pass_cnt++;
    chk_cnt++;
    if (pulse_cnt - base != 1) $display("FAIL pause_tick_pulses: %0d pulses, expected 1", pulse_cnt - base);
    else pass_cnt++;
    repeat (200) begin
      @(negedge clk);
      if (sel !== 3'd5 || step_pulse !== 1'b0) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL pause_stable: %0d bad cycles, expected 0", bad);
    else pass_cnt++;
    want = 3'd5;
    for (int i = 0; i < 3; i++) begin
      push_steps(1, 1'b1);
      want = want - 3'd1;
      #1 base = pulse_cnt;
      press(3'b100);
      #1;
      chk_cnt++;
      if (sel !== want) $display("FAIL manual_step[%0d]: sel=%0d expected %0d", i, sel, want);
      else pass_cnt++;
      chk_cnt++;
      if (pulse_cnt - base != 1) $display("FAIL manual_pulse[%0d]: %0d pulses, expected 1", i, pulse_cnt - base);
      else pass_cnt++;
      chk_cnt++;
      if (speed !== 2'd3) $display("FAIL manual_speed[%0d]: speed=%0d expected 3", i, speed);
      else pass_cnt++;
    end
  endtask

  task automatic test_bounce(output int s_run);
    int base;
    #1 base = pulse_cnt;
    for (int i = 0; i < 20; i++) begin
      key_n[0] = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      key_n[0] = 1'b1;
      repeat ($urandom_range(2, 4)) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    #1;
    chk_cnt++;
    if ({running, dir, speed, sel} !== 7'b0_1_11_010)
      $display("FAIL bounce_state: running,dir,speed,sel=%b expected 0111010", {running, dir, speed, sel});
    else pass_cnt++;
    chk_cnt++;
    if (pulse_cnt != base) $display("FAIL bounce_pulses: %0d pulses, expected 0", pulse_cnt - base);
    else pass_cnt++;
    push_steps(5, 1'b1);
    base = pulse_cnt;
    s_run = cyc;
    press(3'b001);
    #1;
    chk_cnt++;
    if (running !== 1'b1) $display("FAIL bounce_clean: running=%0d expected 1", running);
    else pass_cnt++;
    chk_cnt++;
    if (pulse_cnt - base != 3) $display("FAIL bounce_run_pulses: %0d pulses, expected 3", pulse_cnt - base);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous(input int s_run);
    int g;
    wait_pulse(g);
    chk_cnt++;
    if (g - s_run != 24) $display("FAIL rerun_tick: delay=%0d expected 24", g - s_run);
    else pass_cnt++;
    press(3'b001);
    #1;
    chk_cnt++;
    if (running !== 1'b0 || sel !== 3'd5)
      $display("FAIL sw1_tick: running=%0d sel=%0d expected running=0 sel=5", running, sel);
    else pass_cnt++;
    push_steps(3, 1'b1);
    press(3'b101);
    #1;
    chk_cnt++;
    if (running !== 1'b1) $display("FAIL sw1_sw3_run: running=%0d expected 1", running);
    else pass_cnt++;
    chk_cnt++;
    if (speed !== 2'd3) $display("FAIL sw1_sw3_speed: speed=%0d expected 3", speed);
    else pass_cnt++;
    chk_cnt++;
    if (sel !== 3'd2) $display("FAIL sw1_sw3_sel: sel=%0d expected 2", sel);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({sel, running, dir, speed, step_pulse} !== 8'h00)
      $display("FAIL final_reset: outputs=%b expected 00000000", {sel, running, dir, speed, step_pulse});
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_drained: %0d steps pending, expected 0", exp_q.size());
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int s_run;
    test_reset();
    test_run_cadence();
    test_speed_dir();
    test_pause_step();
    test_bounce(s_run);
    test_simultaneous(s_run);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 50000 cycles");
    $fatal(1);
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Sequencer that drives the 3-bit select input of the board's 3-to-8 active-low LED decoder. It turns the three raw board switches into debounced press events and runs a start/pause/step state machine with selectable direction and speed. It advances the LED index at a prescaled rate. It sits between the switch pins and the decoder's `key_in` input; its `sel` output replaces the direct switch wiring.

## Interface
- `DEB_CYCLES`, default 1_000_000: cycles a synchronized switch level must hold before it is accepted (20 ms at 50 MHz). Minimum 2.
- `TICK_CYCLES`, default 12_000_000: prescaler period at speed 0. Must be a multiple of 8 and at least 8.
- `clk` input 1: system clock, single clock domain.
- `rst` input 1: asynchronous, active-high reset.
- `key_n` input 3: raw board switches, active-low, asynchronous to `clk`.
  - [0] SW1: run/pause.
  - [1] SW2: direction.
  - [2] SW3: speed or step.
- `sel` output 3: LED index to the decoder.
- `running` output 1: high while in the RUN state.
- `dir` output 1: 0 means up (index increments), 1 means down.
- `speed` output 2: 0 is the slowest speed, 3 is the fastest.
- `step_pulse` output 1: high for one cycle on every `sel` change.

## Operation
**Input path (per key)**
- 2-flop synchronizer, both flops reset to 1.
- Debounce counter:
  - Cleared whenever the synced bit equals the debounced level.
  - Otherwise increments.
  - On the cycle it would reach DEB_CYCLES, the debounced level takes the synced value and the counter clears.
- Press event: one-cycle registered pulse on a debounced 1→0 transition. Releases generate no event.

**State machine: IDLE, RUN, PAUSE**
- Reset enters IDLE, with `sel` held at 0.
- SW1 event transitions:
  - IDLE→RUN
  - RUN→PAUSE
  - PAUSE→RUN
- SW2 event: toggles `dir` in any state.
- SW3 event:
  - In IDLE or RUN: `speed` ← `speed`+1, wrapping 3→0.
  - In PAUSE: manual single step of `sel` in the current `dir`.

**Prescaler and stepping**
- Period P = TICK_CYCLES >> `speed` (speed 0: ÷1, 1: ÷2, 2: ÷4, 3: ÷8).
- The counter runs only in RUN.
- It clears to 0 on entry to RUN, on any `speed` change, and when it reaches P-1.
- In RUN, the cycle where the count equals P-1 is a tick.
- Tick or manual step:
  - Up: `sel` ← `sel`+1, wrapping 7→0.
  - Down: `sel` ← `sel`-1, wrapping 0→7.
  - `step_pulse` is registered together with the `sel` update.

**Simultaneous events (same cycle)**
- SW2 is applied first. A step in that same cycle uses the new `dir`.
- SW1 together with SW3: SW3 is discarded and only the state transition occurs.
- SW1 in RUN together with a tick: PAUSE is entered and `sel` does not advance.
- A `speed` change together with a tick: `sel` advances once and the prescaler clears.
- Leaving RUN freezes the prescaler count. Re-entering RUN clears it.

## Timing
**Reset values**
- `sel`=0, `running`=0, `dir`=0, `speed`=0, `step_pulse`=0.
- Internally: state IDLE, debounced levels 1, all counters 0.
- Reset mid-operation returns everything to these values immediately, with no wait for a clock edge.

**Input latency**
- A raw falling edge is set up before clock edge E0.
- The press event is high in the cycle after edge E0+2+DEB_CYCLES.
- The resulting register update (`state`, `dir`, `speed`, `sel`) is visible after edge E0+3+DEB_CYCLES.

**Debounce behaviour**
- A glitch shorter than DEB_CYCLES synced cycles produces no event and no output change.

**Stepping cadence**
- In steady RUN, `step_pulse` recurs exactly every P cycles.
- The first tick occurs P cycles after `running` rises.

**Output timing**
- All outputs are registered. There are no combinational paths from `key_n` to the outputs.

## Test plan
Bench overrides: DEB_CYCLES=4, TICK_CYCLES=32. All presses are held ≥8 cycles and spaced ≥8 cycles after release.
- **Reset and idle:** assert `rst` mid-run with `sel`=5, `dir`=1, `speed`=2.
  - Outputs immediately read 0/0/0/0/0.
  - In IDLE, 100 cycles give no `step_pulse`.
- **Run cadence and wrap-up:** press SW1.
  - `running`=1 exactly 7 cycles after the raw edge.
  - `step_pulse` every 32 cycles.
  - `sel` sequence 1,2,…,7,0.
- **Speed and direction:** in RUN, press SW3 three times, then SW2.
  - P goes 16, 8, 4.
  - `sel` then decrements, with 0→7 wrap checked.
- **Pause and manual step:** press SW1 (PAUSE), wait 200 cycles.
  - `sel` is stable throughout.
  - Each SW3 press steps `sel` by exactly 1 in `dir`, with one `step_pulse` each.
  - `speed` is unchanged.
- **Bounce rejection:** toggle `key_n[0]` with low pulses of 1–3 cycles, 20 times.
  - No state change.
  - Then a clean press gives a single transition.
- **Simultaneous events:** drive SW1 and SW3 presses on the same cycle in PAUSE.
  - Result is RUN with `speed` unchanged.
  - Align a SW1 event with a tick in RUN: result is PAUSE with `sel` not advanced.
